systolic_edge_feeder: RTL and testbench
=======================================

Name: systolic_edge_feeder

Overview:
- Producer end of the PE row/col operand interface. Holds one K-deep operand vector per array lane and streams them into the array edge with the diagonal skew the PE mesh requires: lane i is delayed i cycles.
- One instance drives the row edge and one drives the column edge of an N-lane array.
- A start/busy/done handshake sequences it. Trailing zero cycles let the PE pipeline drain before done.

Parameters:
- N, 4, number of lanes (array rows or columns); ≥1.
- K, 4, operands per lane (inner dimension of the product); ≥1.
- W, 32, lane data width; matches PE row_in/col_in.
- DRAIN, 4, zero-fill cycles after the last operand; ≥0.
- DATA_TYPE, 3'b011, element format: 3'b011 int8 (sign-extend wr_data[7:0] to W); 3'b100 int16 (sign-extend wr_data[15:0]); any other value passes wr_data[W-1:0] unchanged.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  buffer write strobe.
- wr_lane  input  clog2(N) (min 1)  target lane.
- wr_idx  input  clog2(K) (min 1)  operand slot within lane.
- wr_data  input  W  operand; formatted per DATA_TYPE at write time.
- start  input  1  begin a streaming pass (level sampled each cycle).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at end of pass.
- lane_data  output  N*W  lane i occupies bits [i*W +: W]; feeds PE row_in/col_in.
- lane_valid  output  N  bit i high when lane_data lane i carries a real operand.

Behaviour:
- Reset (synchronous, rst high at a clock edge): state IDLE; busy=0, done=0, lane_data=0, lane_valid=0; step counter=0; whole operand buffer cleared to 0. Reset asserted mid-pass aborts the pass with no done pulse.
- Buffer: N×K registers of W bits. In IDLE, wr_en with in-range wr_lane/wr_idx writes the formatted value next edge. Out-of-range indices are ignored. wr_en while busy is ignored, so the buffer stays stable during a pass.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE: start=1 → STREAM, t=0, busy=1 from next cycle. If wr_en and start occur in the same cycle, the write lands and is used by the pass.
- STREAM: lasts exactly K+N-1 cycles (t=0..K+N-2). All outputs are registered. In the cycle where the FSM has step t, lane i shows buf[i][t-i] with lane_valid[i]=1 if 0≤t-i<K; otherwise lane i shows 0 with lane_valid[i]=0. The first visible operand (lane 0, slot 0) appears the cycle after the start edge. After t=K+N-2: → FLUSH if DRAIN>0, else → DONE.
- FLUSH: DRAIN cycles with all lane_data=0 and lane_valid=0, then → DONE.
- DONE: one cycle. done=1, busy=0, outputs 0. Then → IDLE.
- start while busy or in DONE is ignored. No queuing.
- Total: start edge to done-high edge is 1 + (K+N-1) + DRAIN cycles.
- Degenerate cases: N=1 gives no skew. K=1 gives a one-operand diagonal.
- Widths: counters sized for K+N-1+DRAIN with no wrap. Sign-extension is done at write time only; stored values are emitted unmodified.

Test Plan:
- Reset: hold rst 3 cycles after random writes, then start → lane0 first operand is 0, all lane_valid bits consistent with skew, buffer reads back zero.
- Skew: N=4, K=4, DATA_TYPE=3'b111. Write buf[i][k]=16*i+k+1, then start.
  - Lane0 emits 0x01..0x04 on cycles 1..4 after start.
  - Lane3 emits 0x31..0x34 on cycles 4..7.
  - Zeros and lane_valid=0 elsewhere.
  - done high on cycle 12 (1+7+4), busy low that cycle.
- Format: DATA_TYPE=3'b011, write 32'h000000FE → emitted 32'hFFFFFFFE. Write 32'h1234007F → 32'h0000007F.
- Busy protection: during STREAM, pulse start and write buf[0][0]=0xAA → stream unchanged, exactly one done pulse. A second start after done replays identical data.
- Abort: assert rst on STREAM t=2 → next cycle all outputs 0, busy=0, no done. A fresh start after reloading the buffer runs normally.
- Back-to-back: start held high continuously → passes repeat with exactly one IDLE cycle between the done pulse and the next busy.

Source files
------------

// File: rtl/systolic_edge_feeder.sv
// Operand feeder for one edge of an N-lane systolic array.
// Streams K-deep lane vectors with i-cycle skew, then zero-drains.
module systolic_edge_feeder #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int W = 32,
    parameter int DRAIN = 4,
    parameter logic [2:0] DATA_TYPE = 3'b011,
    localparam int LW = (N > 1) ? $clog2(N) : 1,
    localparam int KW = (K > 1) ? $clog2(K) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [LW-1:0]  wr_lane,
    input  logic [KW-1:0]  wr_idx,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] lane_data,
    output logic [N-1:0]   lane_valid
);

    localparam int CW = $clog2(K + N + DRAIN);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [W-1:0] mem_q [N][K];

    logic           wr_ok;
    logic [W-1:0]   wr_fmt;
    logic [N*W-1:0] data_d;
    logic [N-1:0]   valid_d;

    // Sign extension happens once on the way into the buffer.
    always_comb begin
        case (DATA_TYPE)
            3'b011:  wr_fmt = W'($signed(wr_data[7:0]));
            3'b100:  wr_fmt = W'($signed(wr_data[15:0]));
            default: wr_fmt = wr_data;
        endcase
    end

    assign wr_ok = wr_en && (state_q == IDLE)
                   && (int'(wr_lane) < N) && (int'(wr_idx) < K);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    step_d  = '0;
                end
            end
            STREAM: begin
                if (step_q == CW'(K + N - 2)) begin
                    step_d  = '0;
                    state_d = (DRAIN > 0) ? FLUSH : DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            FLUSH: begin
                if (step_q == CW'(DRAIN - 1)) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next step, so a same-edge write
    // must be forwarded into the first slot it would land in.
    always_comb begin
        data_d  = '0;
        valid_d = '0;
        for (int i = 0; i < N; i++) begin
            if (state_d == STREAM && int'(step_d) >= i
                && int'(step_d) - i < K) begin
                valid_d[i] = 1'b1;
                data_d[i*W +: W] = mem_q[i][int'(step_d) - i];
                if (wr_ok && int'(wr_lane) == i
                    && int'(wr_idx) == int'(step_d) - i) begin
                    data_d[i*W +: W] = wr_fmt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lane_data  <= '0;
            lane_valid <= '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K; k++) begin
                    mem_q[i][k] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            busy       <= (state_d == STREAM) || (state_d == FLUSH);
            done       <= (state_d == DONE);
            lane_data  <= data_d;
            lane_valid <= valid_d;
            if (wr_ok) begin
                mem_q[wr_lane][wr_idx] <= wr_fmt;
            end
        end
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder: skew, format, busy guard,
// abort and back-to-back passes on a 4x4 edge with 4 drain cycles.
module tb_systolic_edge_feeder;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = 32;
    localparam int DRAIN = 4;
    localparam int PASS = 1 + (K + N - 1) + DRAIN;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [1:0]     wr_lane;
    logic [1:0]     wr_idx;
    logic [W-1:0]   wr_data;
    logic           start;
    logic           busy, busy_f;
    logic           done, done_f;
    logic [N*W-1:0] lane_data, lane_data_f;
    logic [N-1:0]   lane_valid, lane_valid_f;

    logic [W-1:0]   em [N][K];
    int             n_chk = 0;
    int             n_pass = 0;

    systolic_edge_feeder #(
        .N(N), .K(K), .W(W), .DRAIN(DRAIN), .DATA_TYPE(3'b111)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane),
        .wr_idx(wr_idx), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .lane_data(lane_data),
        .lane_valid(lane_valid)
    );

    systolic_edge_feeder #(
        .N(N), .K(K), .W(W), .DRAIN(DRAIN), .DATA_TYPE(3'b011)
    ) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane),
        .wr_idx(wr_idx), .wr_data(wr_data), .start(start),
        .busy(busy_f), .done(done_f), .lane_data(lane_data_f),
        .lane_valid(lane_valid_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int l, input int k, input logic [W-1:0] d);
        wr_en = 1'b1;
        wr_lane = 2'(l);
        wr_idx = 2'(k);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                em[i][k] = W'(16 * i + k + 1);
                wr(i, k, em[i][k]);
            end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_data"}, 128'(lane_data), 128'(0));
        check({tag, "_valid"}, 128'(lane_valid), 128'(0));
    endtask

    // One full pass checked cycle by cycle against em[][].
    // fmt: write [0][0]=0xFE on the start edge; poke: start+write mid-pass.
    task automatic stream_check(input string tag, input bit fmt,
                                input bit poke);
        logic [N*W-1:0] ed;
        logic [N-1:0]   ev;
        int t, s;
        start = 1'b1;
        if (fmt) begin
            wr_en = 1'b1;
            wr_lane = 2'd0;
            wr_idx = 2'd0;
            wr_data = 32'h0000_00FE;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= PASS; c++) begin
            ed = '0;
            ev = '0;
            t = c - 1;
            for (int i = 0; i < N; i++) begin
                s = t - i;
                if (c <= K + N - 1 && s >= 0 && s < K) begin
                    ev[i] = 1'b1;
                    ed[i*W +: W] = em[i][s];
                end
            end
            check($sformatf("%s_data_c%0d", tag, c), 128'(lane_data), 128'(ed));
            check($sformatf("%s_valid_c%0d", tag, c), 128'(lane_valid), 128'(ev));
            check($sformatf("%s_busy_c%0d", tag, c), 128'(busy),
                  128'(c < PASS));
            check($sformatf("%s_done_c%0d", tag, c), 128'(done),
                  128'(c == PASS));
            if (fmt && c == 1)
                check({tag, "_int8_neg"}, 128'(lane_data_f[0 +: W]),
                      128'(32'hFFFF_FFFE));
            if (fmt && c == 2)
                check({tag, "_int8_pos"}, 128'(lane_data_f[W +: W]),
                      128'(32'h0000_007F));
            if (poke && c == 3) begin
                start = 1'b1;
                wr_en = 1'b1;
                wr_lane = 2'd0;
                wr_idx = 2'd0;
                wr_data = 32'hAA;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        check({tag, "_after_busy"}, 128'(busy), 128'(0));
        check({tag, "_after_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        int  seen;
        bit  found;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_lane = '0;
        wr_idx = '0;
        wr_data = '0;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset");

        // Random writes then reset must clear the buffer.
        for (int j = 0; j < 6; j++)
            wr(j % N, (j * 3) % K, $urandom);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_idle("rst2");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) em[i][k] = '0;
        stream_check("zbuf", 1'b0, 1'b0);

        load_pattern();
        stream_check("skew", 1'b0, 1'b0);

        stream_check("guard", 1'b0, 1'b1);
        stream_check("replay", 1'b0, 1'b0);

        wr(1, 0, 32'h1234_007F);
        em[1][0] = 32'h1234_007F;
        em[0][0] = 32'h0000_00FE;
        stream_check("fmt", 1'b1, 1'b0);

        // Abort at STREAM step 2 (third cycle after the start edge).
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        seen = 0;
        repeat (PASS) begin
            tick();
            if (done) seen++;
        end
        check("abort_no_done", 128'(seen), 128'(0));
        load_pattern();
        stream_check("post_abort", 1'b0, 1'b0);

        // Start held high: one IDLE cycle between done and next busy.
        start = 1'b1;
        tick();
        check("b2b_first", 128'(lane_data[0 +: W]), 128'(32'h1));
        for (int p = 0; p < 2; p++) begin
            found = 1'b0;
            for (int c = 0; c < 2 * PASS && !found; c++) begin
                if (done) found = 1'b1;
                else tick();
            end
            check($sformatf("b2b_done_p%0d", p), 128'(found), 128'(1));
            check($sformatf("b2b_done_busy_p%0d", p), 128'(busy), 128'(0));
            tick();
            check($sformatf("b2b_gap_busy_p%0d", p), 128'(busy), 128'(0));
            check($sformatf("b2b_gap_done_p%0d", p), 128'(done), 128'(0));
            tick();
            check($sformatf("b2b_rerun_busy_p%0d", p), 128'(busy), 128'(1));
            check($sformatf("b2b_rerun_l0_p%0d", p),
                  128'(lane_data[0 +: W]), 128'(32'h1));
        end
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2 * PASS && !found; c++) begin
            if (done) found = 1'b1;
            else tick();
        end
        check("b2b_final_done", 128'(found), 128'(1));
        tick();
        check_idle("end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
